// File: rtl/mult_div_hilo.sv
// mult_div_hilo: multicycle signed MULT/DIV unit that owns the HI and LO registers.
// Latency: done pulses WIDTH+2 cycles after start is sampled in IDLE (HIout/LOout valid with done).
// Backpressure: busy is high in CALC/FIX; start is ignored while busy, op/A/B are only sampled with start.
//
// Ports: clk, reset (async, active-high), start, op (0=MULT, 1=DIV), A, B (signed operands),
//        busy, done, HIout (product high / remainder), LOout (product low / quotient),
//        div0 (only when DIVZERO_EXC_EN is defined).
// Build option: DIVZERO_EXC_EN -- a DIV by zero skips CALC, leaves HI/LO untouched and pulses div0
//        with done. Without it, a DIV by zero takes full latency and forces LO=all-ones, HI=A.
module mult_div_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HIout,
`ifdef DIVZERO_EXC_EN
  output logic [WIDTH-1:0] LOout,
  output logic             div0
`else
  output logic [WIDTH-1:0] LOout
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic             op_r;
  logic             sign_a, sign_b;
  logic             b_zero;
  logic [WIDTH-1:0] a_mag, b_mag;
  // Shared working register: MULT keeps {partial product, remaining multiplier bits},
  // DIV keeps {partial remainder, dividend bits shifting out / quotient bits shifting in}.
  logic [WIDTH-1:0] acc_hi, acc_lo;

  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   mult_sum;
  logic [WIDTH:0]   div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0] quot_s, rem_s, a_orig;
  logic             dz_skip;

  // Magnitudes; the most-negative value maps to 2^(WIDTH-1), which still fits unsigned.
  assign a_abs = A[WIDTH-1] ? (~A + 1'b1) : A;
  assign b_abs = B[WIDTH-1] ? (~B + 1'b1) : B;

  assign mult_sum  = {1'b0, acc_hi} + {1'b0, a_mag};
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  // Remainder stays below the divisor magnitude, so div_shift never overflows WIDTH bits
  // and the top bit of the difference is a clean borrow.
  assign div_diff  = div_shift - {1'b0, b_mag};

  assign prod_s = (sign_a ^ sign_b) ? (~{acc_hi, acc_lo} + 1'b1) : {acc_hi, acc_lo};
  assign quot_s = (sign_a ^ sign_b) ? (~acc_lo + 1'b1) : acc_lo;
  assign rem_s  = sign_a ? (~acc_hi + 1'b1) : acc_hi;
  assign a_orig = sign_a ? (~a_mag + 1'b1) : a_mag;

`ifdef DIVZERO_EXC_EN
  assign dz_skip = 1'b1;
`else
  assign dz_skip = 1'b0;
`endif

  assign busy = (state != IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (dz_skip && op && (B == '0)) state_next = FIX;
          else                            state_next = CALC;
        end
      end
      CALC:    if (cnt == '0) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      op_r   <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      b_zero <= 1'b0;
      a_mag  <= '0;
      b_mag  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      HIout  <= '0;
      LOout  <= '0;
      done   <= 1'b0;
`ifdef DIVZERO_EXC_EN
      div0   <= 1'b0;
`endif
    end else begin
      state <= state_next;
      done  <= 1'b0;
`ifdef DIVZERO_EXC_EN
      div0  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            op_r   <= op;
            sign_a <= A[WIDTH-1];
            sign_b <= B[WIDTH-1];
            b_zero <= (B == '0);
            a_mag  <= a_abs;
            b_mag  <= b_abs;
            cnt    <= CW'(WIDTH - 1);
            acc_hi <= '0;
            acc_lo <= op ? a_abs : b_abs;
          end
        end
        CALC: begin
          cnt <= cnt - CW'(1);
          if (!op_r) begin
            // Shift-add: add multiplicand if the current multiplier LSB is set, then shift right.
            if (acc_lo[0]) begin
              acc_hi <= mult_sum[WIDTH:1];
              acc_lo <= {mult_sum[0], acc_lo[WIDTH-1:1]};
            end else begin
              acc_hi <= {1'b0, acc_hi[WIDTH-1:1]};
              acc_lo <= {acc_hi[0], acc_lo[WIDTH-1:1]};
            end
          end else begin
            // Restoring step: keep the difference only when it did not borrow.
            if (!div_diff[WIDTH]) acc_hi <= div_diff[WIDTH-1:0];
            else                  acc_hi <= div_shift[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};
          end
        end
        FIX: begin
          done <= 1'b1;
          if (!op_r) begin
            HIout <= prod_s[2*WIDTH-1:WIDTH];
            LOout <= prod_s[WIDTH-1:0];
          end else if (b_zero) begin
`ifdef DIVZERO_EXC_EN
            div0  <= 1'b1;
`else
            HIout <= a_orig;
            LOout <= '1;
`endif
          end else begin
            HIout <= rem_s;
            LOout <= quot_s;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_hilo.sv
module tb_mult_div_hilo;

  logic        clk;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;
`ifdef DIVZERO_EXC_EN
  logic        div0;
`endif

  int checks = 0;
  int passed = 0;

  // Architectural view of HI/LO as the bench expects it.
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  mult_div_hilo #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (a),
    .B     (b),
    .busy  (busy),
    .done  (done),
    .HIout (hi),
`ifdef DIVZERO_EXC_EN
    .LOout (lo),
    .div0  (div0)
`else
    .LOout (lo)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: signed arithmetic on 64-bit integers.
  function automatic void model(input logic o, input logic [31:0] x, input logic [31:0] y,
                                inout logic [31:0] h, inout logic [31:0] l);
    longint sx, sy, p, q, r;
    logic [63:0] pv;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (!o) begin
      p  = sx * sy;
      pv = p;
      h  = pv[63:32];
      l  = pv[31:0];
    end else if (y == 32'd0) begin
`ifndef DIVZERO_EXC_EN
      h = x;
      l = 32'hFFFF_FFFF;
`endif
    end else begin
      q  = sx / sy;
      r  = sx % sy;
      pv = q;
      l  = pv[31:0];
      pv = r;
      h  = pv[31:0];
    end
  endfunction

  function automatic int exp_lat(input logic o, input logic [31:0] y);
`ifdef DIVZERO_EXC_EN
    if (o && y == 32'd0) return 2;
`endif
    return 34;
  endfunction

  // Issue one operation and count cycles until done (start cycle = 0); -1 on timeout.
  // Operands are scrambled while busy: they must have no effect.
  task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y, output int lat);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = ~o; a = $urandom; b = $urandom;
    lat = 1;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done) lat = -1;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    checks++; if (hi !== 32'd0) $display("FAIL reset_hi got %h want 0", hi); else passed++;
    checks++; if (lo !== 32'd0) $display("FAIL reset_lo got %h want 0", lo); else passed++;
`ifdef DIVZERO_EXC_EN
    checks++; if (div0 !== 1'b0) $display("FAIL reset_div0 got %b want 0", div0); else passed++;
`endif
  endtask

  task automatic test_mult;
    logic [31:0] xs[3] = '{32'd7, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] ys[3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] x, y;
    int lat;
    for (int i = 0; i < 23; i++) begin
      if (i < 3) begin x = xs[i]; y = ys[i]; end
      else begin x = $urandom; y = $urandom; if (i % 4 == 0) y = y >> $urandom_range(31, 16); end
      model(1'b0, x, y, exp_hi, exp_lo);
      run_op(1'b0, x, y, lat);
      checks++; if (lat != 34) $display("FAIL mult_lat %h*%h got %0d want 34", x, y, lat); else passed++;
      checks++; if (hi !== exp_hi) $display("FAIL mult_hi %h*%h got %h want %h", x, y, hi, exp_hi); else passed++;
      checks++; if (lo !== exp_lo) $display("FAIL mult_lo %h*%h got %h want %h", x, y, lo, exp_lo); else passed++;
    end
  endtask

  task automatic test_div;
    logic [31:0] xs[3] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000};
    logic [31:0] ys[3] = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    logic [31:0] x, y;
    int lat;
    for (int i = 0; i < 23; i++) begin
      if (i < 3) begin x = xs[i]; y = ys[i]; end
      else begin
        x = $urandom;
        y = $urandom >> $urandom_range(30, 0);
        if ($urandom_range(1, 0) == 1) y = -y;
        if (y == 32'd0) y = 32'd3;
      end
      model(1'b1, x, y, exp_hi, exp_lo);
      run_op(1'b1, x, y, lat);
      checks++; if (lat != 34) $display("FAIL div_lat %h/%h got %0d want 34", x, y, lat); else passed++;
      checks++; if (hi !== exp_hi) $display("FAIL div_hi %h/%h got %h want %h", x, y, hi, exp_hi); else passed++;
      checks++; if (lo !== exp_lo) $display("FAIL div_lo %h/%h got %h want %h", x, y, lo, exp_lo); else passed++;
    end
  endtask

  task automatic test_divzero;
    int lat;
    // 697 / 20 -> quotient 0x22, remainder 0x11 preloads LO/HI.
    model(1'b1, 32'd697, 32'd20, exp_hi, exp_lo);
    run_op(1'b1, 32'd697, 32'd20, lat);
    checks++; if (hi !== 32'h11 || lo !== 32'h22) $display("FAIL dz_preload got %h/%h want 11/22", hi, lo); else passed++;
    model(1'b1, 32'd5, 32'd0, exp_hi, exp_lo);
    run_op(1'b1, 32'd5, 32'd0, lat);
    checks++; if (lat != exp_lat(1'b1, 32'd0)) $display("FAIL dz_lat got %0d want %0d", lat, exp_lat(1'b1, 32'd0)); else passed++;
`ifdef DIVZERO_EXC_EN
    checks++; if (div0 !== 1'b1) $display("FAIL dz_flag got %b want 1", div0); else passed++;
`endif
    checks++; if (hi !== exp_hi) $display("FAIL dz_hi got %h want %h", hi, exp_hi); else passed++;
    checks++; if (lo !== exp_lo) $display("FAIL dz_lo got %h want %h", lo, exp_lo); else passed++;
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) $display("FAIL dz_done_pulse got %b want 0", done); else passed++;
`ifdef DIVZERO_EXC_EN
    checks++; if (div0 !== 1'b0) $display("FAIL dz_flag_pulse got %b want 0", div0); else passed++;
`endif
  endtask

  task automatic test_start_ignored;
    logic [31:0] x, y;
    int ndone, first;
    logic [31:0] got_hi, got_lo;
    x = $urandom; y = $urandom;
    model(1'b0, x, y, exp_hi, exp_lo);
    ndone = 0; first = -1; got_hi = '0; got_lo = '0;
    @(negedge clk);
    op = 1'b0; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (cyc == 5 || cyc == 20) begin
        start = 1'b1; op = 1'b1; a = $urandom; b = $urandom;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        ndone++;
        if (ndone == 1) begin first = cyc; got_hi = hi; got_lo = lo; end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    checks++; if (ndone != 1) $display("FAIL ign_done_count got %0d want 1", ndone); else passed++;
    checks++; if (first != 34) $display("FAIL ign_lat got %0d want 34", first); else passed++;
    checks++; if (got_hi !== exp_hi || got_lo !== exp_lo)
      $display("FAIL ign_result got %h_%h want %h_%h", got_hi, got_lo, exp_hi, exp_lo); else passed++;
    checks++; if (hi !== exp_hi || lo !== exp_lo)
      $display("FAIL ign_hold got %h_%h want %h_%h", hi, lo, exp_hi, exp_lo); else passed++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] x, y;
    int lat;
    x = $urandom; y = $urandom;
    model(1'b0, x, y, exp_hi, exp_lo);
    run_op(1'b0, x, y, lat);
    checks++; if (lat != 34) $display("FAIL b2b_first_lat got %0d want 34", lat); else passed++;
    // Still inside the done cycle: issue the next op here.
    x = $urandom; y = ($urandom >> 8) | 32'd1;
    model(1'b1, x, y, exp_hi, exp_lo);
    op = 1'b1; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
    checks++; if (lat != 34) $display("FAIL b2b_second_lat got %0d want 34", lat); else passed++;
    checks++; if (hi !== exp_hi) $display("FAIL b2b_hi got %h want %h", hi, exp_hi); else passed++;
    checks++; if (lo !== exp_lo) $display("FAIL b2b_lo got %h want %h", lo, exp_lo); else passed++;
  endtask

  task automatic test_reset_abort;
    int ndone, lat;
    logic [31:0] x, y;
    @(negedge clk);
    op = 1'b0; a = 32'h1234_5678; b = 32'h0BAD_F00D; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) begin @(posedge clk); #1; end
    #2 reset = 1'b1;
    #1;
    exp_hi = '0; exp_lo = '0;
    checks++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else passed++;
    checks++; if (hi !== 32'd0 || lo !== 32'd0) $display("FAIL abort_hilo got %h_%h want 0_0", hi, lo); else passed++;
    @(negedge clk); reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    checks++; if (ndone != 0) $display("FAIL abort_no_done got %0d want 0", ndone); else passed++;
    x = $urandom; y = $urandom;
    model(1'b0, x, y, exp_hi, exp_lo);
    run_op(1'b0, x, y, lat);
    checks++; if (lat != 34) $display("FAIL abort_next_lat got %0d want 34", lat); else passed++;
    checks++; if (hi !== exp_hi || lo !== exp_lo)
      $display("FAIL abort_next_result got %h_%h want %h_%h", hi, lo, exp_hi, exp_lo); else passed++;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_divzero();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
